// File: rtl/os_result_collector_if.sv
// Drain-side and stream-side signals of the output-stationary result collector.
interface os_result_collector_if #(
  parameter int unsigned D_W = 8,
  parameter int unsigned N   = 3
);
  localparam int unsigned RW = 2 * D_W;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0][RW-1:0] m2;
  logic [N-1:0]         valid_m2;
  logic [RW-1:0]        out_data;
  logic [IW-1:0]        out_row;
  logic [IW-1:0]        out_col;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  // Collector side: sinks the drained rows, sources the tile stream.
  modport master (
    input  m2, valid_m2, out_ready,
    output out_data, out_row, out_col, out_valid, out_last
  );

  // Array / consumer side.
  modport slave (
    output m2, valid_m2, out_ready,
    input  out_data, out_row, out_col, out_valid, out_last
  );
endinterface

// File: rtl/os_result_collector.sv
// Reassembles reverse-column drained row streams into an N x N tile and
// replays it row-major on a valid/ready stream. Single tile buffer.
module os_result_collector #(
  parameter int unsigned D_W  = 8,
  parameter int unsigned N    = 3,
  parameter int unsigned TC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  os_result_collector_if.master    bus,
  output logic                     busy,
  output logic                     overflow,
  output logic                     tile_done,
  output logic [TC_W-1:0]          tile_count
);
  localparam int unsigned RW = 2 * D_W;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic {COLLECT, STREAM} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt   [N];
  logic [CW-1:0]   cnt_d [N];
  logic [IW-1:0]   wcol  [N];
  logic [IW-1:0]   r, c, r_d, c_d;
  logic [N-1:0]    wr_en;
  logic            ovf_d, done_d, all_full;
  logic [TC_W-1:0] count_d;
  logic [RW-1:0]   tile_buf [N][N];

  // Column written by the next beat on each row: column N-1 drains first.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      wcol[k] = IW'(N - 1) - IW'(cnt[k]);
    end
  end

  // Next-state: beat capture in COLLECT, index walk and tile completion in STREAM.
  always_comb begin
    state_d  = state;
    r_d      = r;
    c_d      = c;
    ovf_d    = overflow;
    done_d   = 1'b0;
    count_d  = tile_count;
    wr_en    = '0;
    all_full = 1'b1;
    for (int k = 0; k < N; k++) begin
      cnt_d[k] = cnt[k];
    end
    case (state)
      COLLECT: begin
        for (int k = 0; k < N; k++) begin
          if (bus.valid_m2[k]) begin
            if (cnt[k] < CW'(N)) begin
              wr_en[k] = 1'b1;
              cnt_d[k] = cnt[k] + CW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        for (int k = 0; k < N; k++) begin
          if (cnt_d[k] != CW'(N)) all_full = 1'b0;
        end
        if (all_full) state_d = STREAM;
      end
      STREAM: begin
        // Buffer stays owned by the stream up to and including the last handshake.
        if (|bus.valid_m2) ovf_d = 1'b1;
        if (bus.out_ready) begin
          if (c == IW'(N - 1)) begin
            c_d = '0;
            if (r == IW'(N - 1)) begin
              state_d = COLLECT;
              r_d     = '0;
              count_d = tile_count + TC_W'(1);
              done_d  = 1'b1;
              for (int k = 0; k < N; k++) begin
                cnt_d[k] = '0;
              end
            end else begin
              r_d = r + IW'(1);
            end
          end else begin
            c_d = c + IW'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= COLLECT;
      r          <= '0;
      c          <= '0;
      overflow   <= 1'b0;
      tile_done  <= 1'b0;
      tile_count <= '0;
      for (int k = 0; k < N; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      state      <= state_d;
      r          <= r_d;
      c          <= c_d;
      overflow   <= ovf_d;
      tile_done  <= done_d;
      tile_count <= count_d;
      for (int k = 0; k < N; k++) begin
        cnt[k] <= cnt_d[k];
      end
    end
  end

  // Tile storage; contents are meaningless until a full drain lands.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (wr_en[k]) tile_buf[k][wcol[k]] <= bus.m2[k];
    end
  end

  // Stream outputs decoded from the registered state and indices.
  always_comb begin
    bus.out_valid = (state == STREAM);
    bus.out_last  = (state == STREAM) && (r == IW'(N - 1)) && (c == IW'(N - 1));
    bus.out_data  = tile_buf[r][c];
    bus.out_row   = r;
    bus.out_col   = c;
    busy          = (state == STREAM);
  end
endmodule

// File: tb/tb_os_result_collector.sv
// Randomized bench for os_result_collector against a tile-level reference model.
module tb_os_result_collector;
  localparam int unsigned D_W  = 8;
  localparam int unsigned N    = 3;
  localparam int unsigned TC_W = 2;
  localparam int TC_MOD = 1 << TC_W;

  logic clk;
  logic rst;
  logic busy, overflow, tile_done;
  logic [TC_W-1:0] tile_count;

  os_result_collector_if #(.D_W(D_W), .N(N)) bus ();

  os_result_collector #(.D_W(D_W), .N(N), .TC_W(TC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .overflow   (overflow),
    .tile_done  (tile_done),
    .tile_count (tile_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: schedule of beats per row, expected tile, sticky flags.
  int sched  [N][N+1];
  int val    [N][N+1];
  int nbeats [N];
  int exp_buf[N][N];
  int tc_exp;
  int ovf_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive the beat schedule; expected tile is filled by beat order (column N-1 first).
  task automatic drain();
    int fill[N];
    int sent[N];
    int last_cyc;
    bit pending;
    last_cyc = 0;
    for (int k = 0; k < N; k++) begin
      fill[k] = 0;
      sent[k] = 0;
      for (int b = 0; b < nbeats[k]; b++) if (sched[k][b] > last_cyc) last_cyc = sched[k][b];
    end
    for (int cyc = 0; cyc <= last_cyc; cyc++) begin
      @(posedge clk); #1;
      pending = 1'b0;
      for (int k = 0; k < N; k++) if (fill[k] < N) pending = 1'b1;
      if (pending) check("collect_idle", 32'(bus.out_valid), 32'd0);
      bus.valid_m2 = '0;
      for (int k = 0; k < N; k++) begin
        if (sent[k] < nbeats[k] && sched[k][sent[k]] == cyc) begin
          bus.valid_m2[k] = 1'b1;
          bus.m2[k] = 16'(val[k][sent[k]]);
          if (fill[k] < N) begin
            exp_buf[k][N-1-fill[k]] = val[k][sent[k]];
            fill[k]++;
          end else begin
            ovf_exp = 1;
          end
          sent[k]++;
        end
      end
    end
    @(posedge clk); #1;
    bus.valid_m2 = '0;
    check("stream_latency", 32'(bus.out_valid), 32'd1);
    check("busy_stream", 32'(busy), 32'd1);
    check("overflow_collect", 32'(overflow), 32'(ovf_exp));
  endtask

  // Consume the tile; mode 0 ready=1, 1 pattern 1,0,0,1, 2 random.
  task automatic stream_tile(input int mode, input bit inject_last, input int reset_after);
    int hs, cyc, r, c;
    bit rdy;
    hs = 0;
    cyc = 0;
    while (hs < N * N) begin
      if (cyc > 400) begin
        check("stream_timeout", 32'(hs), 32'(N * N));
        break;
      end
      r = hs / N;
      c = hs % N;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = rdy;
      bus.valid_m2 = '0;
      if (inject_last && rdy && hs == N * N - 1) begin
        bus.valid_m2 = '1;
        ovf_exp = 1;
      end
      check("s_valid", 32'(bus.out_valid), 32'd1);
      check("s_data", 32'(bus.out_data), 32'(exp_buf[r][c]));
      check("s_row", 32'(bus.out_row), 32'(r));
      check("s_col", 32'(bus.out_col), 32'(c));
      check("s_last", 32'(bus.out_last), 32'((r == N - 1) && (c == N - 1)));
      @(posedge clk); #1;
      if (rdy) hs++;
      cyc++;
      if (reset_after > 0 && hs == reset_after) begin
        #2 rst = 1'b0;
        #1;
        tc_exp = 0;
        ovf_exp = 0;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_last", 32'(bus.out_last), 32'd0);
        check("rst_count", 32'(tile_count), 32'd0);
        check("rst_done", 32'(tile_done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        bus.out_ready = 1'b0;
        bus.valid_m2 = '0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
    end
    bus.valid_m2 = '0;
    bus.out_ready = 1'b0;
    tc_exp = (tc_exp + 1) % TC_MOD;
    check("tile_done", 32'(tile_done), 32'd1);
    check("end_valid", 32'(bus.out_valid), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("tile_count", 32'(tile_count), 32'(tc_exp));
    check("overflow_end", 32'(overflow), 32'(ovf_exp));
  endtask

  task automatic random_sched();
    int cyc;
    for (int k = 0; k < N; k++) begin
      nbeats[k] = N;
      cyc = int'($urandom_range(0, 2));
      for (int b = 0; b < N; b++) begin
        sched[k][b] = cyc;
        val[k][b] = int'($urandom_range(0, 65535));
        cyc += 1 + int'($urandom_range(0, 2));
      end
    end
  endtask

  initial begin
    tc_exp = 0;
    ovf_exp = 0;
    rst = 1'b0;
    bus.m2 = '0;
    bus.valid_m2 = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    check("reset_done", 32'(tile_done), 32'd0);
    check("reset_count", 32'(tile_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Aligned drain, value 10*k+b.
    for (int k = 0; k < N; k++) begin
      nbeats[k] = N;
      for (int b = 0; b < N; b++) begin
        sched[k][b] = b;
        val[k][b] = 10 * k + b;
      end
    end
    drain();
    check("plan_elem00", 32'(bus.out_data), 32'd2);
    stream_tile(0, 1'b0, 0);

    // Skewed rows with gaps; row 2 starts four cycles after row 0.
    random_sched();
    sched[0][0] = 0; sched[0][1] = 1; sched[0][2] = 2;
    sched[1][0] = 1; sched[1][1] = 2; sched[1][2] = 4;
    sched[2][0] = 4; sched[2][1] = 6; sched[2][2] = 7;
    drain();
    stream_tile(0, 1'b0, 0);

    // Backpressure 1,0,0,1.
    random_sched();
    drain();
    stream_tile(1, 1'b0, 0);

    // Fourth beat on row 1 in COLLECT, then a beat on the last handshake.
    random_sched();
    nbeats[1] = N + 1;
    sched[0][0] = 0; sched[0][1] = 2; sched[0][2] = 4;
    sched[1][0] = 0; sched[1][1] = 1; sched[1][2] = 2; sched[1][3] = 3;
    val[1][3] = 16'hBEEF;
    sched[2][0] = 1; sched[2][1] = 3; sched[2][2] = 5;
    drain();
    stream_tile(2, 1'b1, 0);

    // Async reset after element (1,1) is handed off.
    random_sched();
    drain();
    stream_tile(0, 1'b0, 5);

    // Back-to-back tiles across the tile_count wrap.
    for (int t = 0; t < TC_MOD + 1; t++) begin
      random_sched();
      drain();
      stream_tile(2, 1'b0, 0);
    end
    check("wrap_count", 32'(tile_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/os_result_collector.md
Name: os_result_collector

Overview:
- Downstream stage of the output-stationary systolic array.
- Consumes the per-row drained result streams (m2/valid_m2) during the reverse-column drain and reassembles them into an N x N result tile.
- Replays the tile row-major on a valid/ready stream to the result writer and fault-comparison logic.
- Single tile buffer; flags drained beats it cannot accept.

Parameters:
D_W, 8, operand width; result width is 2*D_W
N, 3, array dimension (rows = columns); N >= 2 required
TC_W, 16, width of tile_count

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (asserted when 0)
m2  input  [2*D_W-1:0] x N  per-row drained result from array column N-1
valid_m2  input  N  per-row beat valid
out_data  output  2*D_W  tile element buf[out_row][out_col]
out_row  output  $clog2(N)  row index of out_data
out_col  output  $clog2(N)  column index of out_data
out_valid  output  1  stream valid
out_ready  input  1  stream ready from consumer
out_last  output  1  high with element (N-1,N-1)
busy  output  1  high in STREAM state
overflow  output  1  sticky: a valid beat was dropped
tile_done  output  1  one-cycle pulse on final stream handshake
tile_count  output  TC_W  completed tiles, wraps at 2^TC_W

Behaviour:
- Reset (rst=0, async): state=COLLECT, all row beat counters=0, stream indices r=c=0, overflow=0, tile_count=0, tile_done=0, out_valid=0. Buffer contents are don't-care.
- Handshake: transfer when out_valid && out_ready.
- Column mapping: array drains column N-1 first. The b-th valid beat (b=0..N-1) on row k is column N-1-b and is written to buf[k][N-1-b].
- COLLECT state:
  - Per row k, valid_m2[k] with cnt[k]<N stores the beat and increments cnt[k]. Rows are independent; any subset may be valid in the same cycle, including non-consecutive cycles.
  - valid_m2[k] with cnt[k]==N means the row is already full: beat dropped, overflow set to 1.
  - When the edge's next-state counters are all N (the final beat's edge included), state goes to STREAM on that same edge.
  - Latency: out_valid=1 in the first cycle after the edge capturing the last beat.
- STREAM state:
  - out_valid=1, busy=1; out_data/out_row/out_col reflect buf[r][c], combinationally from registered r,c.
  - On handshake: c increments. When c=N-1, c goes to 0 and r increments.
  - Outputs hold stable while out_ready=0 (no data change, no index change).
  - out_last=1 exactly when r=N-1 and c=N-1.
  - On the last handshake: state goes to COLLECT, counters clear to 0, r=c=0, tile_count increments (wrap), tile_done=1 for one cycle.
  - Any valid_m2 bit set during STREAM: beat dropped, overflow set. This includes the cycle of the last handshake, because the buffer is not yet free.
- out_valid=0, out_last=0, busy=0 in COLLECT. out_data is don't-care when out_valid=0.
- overflow is cleared only by reset.
- Reset mid-tile or mid-stream discards everything: state COLLECT, counters 0, no tile_done, tile_count=0.

Test Plan:
- N=3 drain: rows emit 3 beats each on cycles t..t+2, row k beat b value = 10*k+b. Required stream, out_valid from t+3:
  - row 0: (0,0)=2, (0,1)=1, (0,2)=0
  - row 1: (1,0)=12, (1,1)=11, (1,2)=10
  - row 2: (2,0)=22, (2,1)=21, (2,2)=20
  - out_last only on (2,2); tile_count=1; one tile_done pulse.
- Skewed rows: row 2 beats arrive 4 cycles after row 0's, with gaps. STREAM is entered only after row 2's third beat, and data is mapped correctly.
- Backpressure: out_ready toggles 1,0,0,1 repeatedly. Each element is held while ready=0, all 9 elements are delivered in order, none duplicated.
- Overflow:
  - A 4th beat on row 1 in COLLECT: overflow=1, tile contents unchanged.
  - A beat during STREAM: dropped, overflow stays 1.
- Reset: drive rst=0 asynchronously after element (1,1) is handed off. Outputs go to reset values immediately; the next full drain streams a fresh tile with tile_count=1.
- Back-to-back tiles: 2^TC_W+1 tiles with TC_W=2 (5 tiles) → tile_count reads 1 after wrap.
